// File: rtl/alu_mb_seq.sv
// rtl/alu_mb_seq.sv - multi-byte operation sequencer driving an 8-bit ALU one byte per clock
// Chains carry/borrow between bytes and accumulates the wide result and C/Z flags.
module alu_mb_seq #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [2:0]   OP,
    input  logic [W-1:0] OPA,
    input  logic [W-1:0] OPB,
    input  logic         CIN_EXT,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RESULT_WIDE,
    output logic         C_OUT,
    output logic         Z_OUT,
    output logic [3:0]   ALU_SEL,
    output logic [7:0]   ALU_A,
    output logic [7:0]   ALU_B,
    output logic         ALU_CIN,
    input  logic [7:0]   ALU_RESULT,
    input  logic         ALU_C,
    input  logic         ALU_Z
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LSL = 3'd6;
    localparam logic [2:0] OP_LSR = 3'd7;
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [2:0]   idx_q, idx_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] work_q, work_d;
    logic [W-1:0] result_q, result_d;
    logic         carry_q, carry_d;
    logic         zacc_q, zacc_d;
    logic         c_q, c_d;
    logic         z_q, z_d;

    logic [2:0]   byte_sel;
    logic         first;
    logic         accept;

    // LSR walks from the top byte down so the shift-in bit enters at the MSB
    assign byte_sel = (op_q == OP_LSR) ? (LAST_IDX - idx_q) : idx_q;
    assign first    = (idx_q == 3'd0);
    assign accept   = START && (state_q != S_RUN);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        c_d      = c_q;
        z_d      = z_q;
        ALU_SEL  = 4'hF;
        ALU_A    = 8'h00;
        ALU_B    = 8'h00;
        ALU_CIN  = 1'b0;

        case (state_q)
            S_RUN: begin
                ALU_A   = a_q[8*byte_sel +: 8];
                ALU_B   = (op_q == OP_LSL || op_q == OP_LSR) ? 8'h00 : b_q[8*byte_sel +: 8];
                ALU_CIN = carry_q;
                case (op_q)
                    OP_ADD:  ALU_SEL = first ? 4'd0 : 4'd1;
                    OP_SUB:  ALU_SEL = first ? 4'd2 : 4'd3;
                    OP_CMP:  ALU_SEL = first ? 4'd4 : 4'd3;
                    OP_AND:  ALU_SEL = 4'd5;
                    OP_OR:   ALU_SEL = 4'd6;
                    OP_XOR:  ALU_SEL = 4'd7;
                    OP_LSL:  ALU_SEL = 4'd9;
                    default: ALU_SEL = 4'd10;
                endcase
                work_d[8*byte_sel +: 8] = ALU_RESULT;
                carry_d = ALU_C;
                zacc_d  = zacc_q & ALU_Z;
                idx_d   = idx_q + 3'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    c_d     = ALU_C;
                    z_d     = zacc_q & ALU_Z;
                    if (op_q != OP_CMP) begin
                        result_d = work_d;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // DONE+START chains straight into the next operation
        if (accept) begin
            state_d = S_RUN;
            op_d    = OP;
            a_d     = OPA;
            b_d     = OPB;
            idx_d   = 3'd0;
            carry_d = (OP == OP_LSL || OP == OP_LSR) ? CIN_EXT : 1'b0;
            zacc_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            idx_q    <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    assign BUSY        = (state_q == S_RUN);
    assign DONE        = (state_q == S_DONE);
    assign RESULT_WIDE = result_q;
    assign C_OUT       = c_q;
    assign Z_OUT       = z_q;
endmodule

// File: tb/tb_alu_mb_seq.sv
// tb/tb_alu_mb_seq.sv - scoreboard bench for alu_mb_seq with a behavioural 8-bit ALU
module tb_alu_mb_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opa, opb;
    logic         cin_ext;
    logic         busy, done, c_out, z_out;
    logic [W-1:0] result_wide;
    logic [3:0]   alu_sel;
    logic [7:0]   alu_a, alu_b, alu_result;
    logic         alu_cin, alu_c, alu_z;

    alu_mb_seq #(.NBYTES(NB)) dut (
        .CLK(clk), .RST(rst), .START(start), .OP(op), .OPA(opa), .OPB(opb),
        .CIN_EXT(cin_ext), .BUSY(busy), .DONE(done), .RESULT_WIDE(result_wide),
        .C_OUT(c_out), .Z_OUT(z_out), .ALU_SEL(alu_sel), .ALU_A(alu_a),
        .ALU_B(alu_b), .ALU_CIN(alu_cin), .ALU_RESULT(alu_result),
        .ALU_C(alu_c), .ALU_Z(alu_z)
    );

    always #5 clk = ~clk;

    // Combinational RAT ALU
    logic [8:0] t;
    always_comb begin
        t = 9'd0;
        case (alu_sel)
            4'd0:  t = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:  t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            4'd2:  t = {1'b0, alu_a} - {1'b0, alu_b};
            4'd3:  t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
            4'd4:  t = {1'b0, alu_a} - {1'b0, alu_b};
            4'd5:  t = {1'b0, alu_a & alu_b};
            4'd6:  t = {1'b0, alu_a | alu_b};
            4'd7:  t = {1'b0, alu_a ^ alu_b};
            4'd9:  t = {alu_a[7], alu_a[6:0], alu_cin};
            4'd10: t = {alu_a[0], alu_cin, alu_a[7:1]};
            default: t = 9'd0;
        endcase
        alu_result = t[7:0];
        alu_c      = t[8];
        alu_z      = (t[7:0] == 8'd0);
    end

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    exp_t         exp_q[$];
    logic [3:0]   sel_trace[$];
    logic [7:0]   a_trace[$];
    logic [W-1:0] last_res;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (busy) begin
            sel_trace.push_back(alu_sel);
            a_trace.push_back(alu_a);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result_wide, e.res);
                check("c_out", c_out, e.c);
                check("z_out", z_out, e.z);
                check("busy_in_done", busy, 0);
            end
        end
    end

    // Wide reference model, independent of the byte sequencing
    task automatic push_exp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        logic [W:0] d;
        d = '0;
        case (o)
            3'd0: d = {1'b0, a} + {1'b0, b};
            3'd1, 3'd2: d = {1'b0, a} - {1'b0, b};
            3'd3: d = {1'b0, a & b};
            3'd4: d = {1'b0, a | b};
            3'd5: d = {1'b0, a ^ b};
            3'd6: d = {a, ci};
            default: d = {a[0], ci, a[W-1:1]};
        endcase
        e.c   = d[W];
        e.z   = (d[W-1:0] == '0);
        e.res = (o == 3'd2) ? last_res : d[W-1:0];
        last_res = e.res;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        op = o; opa = a; opb = b; cin_ext = ci; start = 1'b1;
        push_exp(o, a, b, ci);
    endtask

    // Counts edges from the accepting edge until DONE is visible
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (!done && n < 64);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, output int n);
        drive(o, a, b, ci);
        wait_done(n);
        @(posedge clk); #1;
    endtask

    logic [63:0] pack;
    int lat;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; opa = '0; opb = '0; cin_ext = 1'b0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result_wide, 0);
        check("rst_c", c_out, 0);
        check("rst_z", z_out, 0);
        check("rst_alu_sel", alu_sel, 4'hF);
        check("rst_alu_a", alu_a, 0);

        // ADD with carry chain, latency and SEL sequence
        sel_trace.delete();
        run_op(3'd0, 32'h0000FFFF, 32'h00000001, 1'b0, lat);
        check("add_latency", lat, NB + 1);
        pack = 0;
        foreach (sel_trace[i]) pack = (pack << 4) | 64'(sel_trace[i]);
        check("add_sel_seq", pack, 64'h0111);
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        check("idle_alu_sel", alu_sel, 4'hF);

        run_op(3'd1, 32'h00000000, 32'h00000001, 1'b0, lat);
        run_op(3'd2, 32'h12345678, 32'h12345678, 1'b0, lat);
        run_op(3'd2, 32'h00000100, 32'h00000200, 1'b0, lat);

        run_op(3'd6, 32'h80000001, 32'h0, 1'b1, lat);
        a_trace.delete();
        run_op(3'd7, 32'h00000001, 32'hFFFFFFFF, 1'b1, lat);
        pack = 0;
        foreach (a_trace[i]) pack = (pack << 8) | 64'(a_trace[i]);
        check("lsr_a_seq", pack, 64'h00000001);

        run_op(3'd5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, lat);
        run_op(3'd4, 32'h00000000, 32'h00010000, 1'b0, lat);
        run_op(3'd3, 32'hF0F0FF00, 32'h0FF0F0F0, 1'b0, lat);

        // START pulsed throughout RUN must be ignored
        drive(3'd0, 32'h00000010, 32'h00000020, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) begin
            opa = $urandom;
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("ignore_start_done", done, 1);
        @(posedge clk); #1;
        check("back_to_idle", busy, 0);

        // Back-to-back: START during DONE
        drive(3'd1, 32'h00001000, 32'h00000001, 1'b0);
        wait_done(lat);
        drive(3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        check("b2b_interval", lat, NB + 1);
        @(posedge clk); #1;

        // Reset on the second RUN cycle
        drive(3'd0, 32'h11111111, 32'h22222222, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        last_res = '0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result_wide, 0);
        check("mid_rst_c", c_out, 0);
        check("mid_rst_z", z_out, 0);
        check("mid_rst_alu_sel", alu_sel, 4'hF);
        repeat (8) @(posedge clk);
        #1;
        run_op(3'd0, 32'h00000001, 32'h00000001, 1'b0, lat);
        check("post_rst_result", result_wide, 32'h00000002);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
